// File: rtl/spi_host_streamer_if.sv
// Stream, SPI pin and result bundle for spi_host_streamer.
//
// Signals:
//   start        - one-cycle pulse that begins a frame when the host is idle
//   in_valid     - pixel byte available on in_data
//   in_data      - packed pixel byte, bit 7 goes out first
//   in_ready     - byte accepted when in_valid & in_ready
//   miso         - serial data returned by the recognizer
//   sck/ss/mosi  - SPI clock (idle low), select (active low), serial data out
//   busy         - host is working on a frame
//   result_valid - one-cycle pulse when the digit has been read back
//   result_digit - low nibble of the byte read back
//   result_err   - byte read back is not a legal digit
//
// Modports:
//   master - upstream side (pixel source, result consumer, SPI target pins)
//   slave  - the streamer itself
interface spi_host_streamer_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       miso;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       busy;
  logic       result_valid;
  logic [3:0] result_digit;
  logic       result_err;

  modport master (
    output start, in_valid, in_data, miso,
    input  in_ready, sck, ss, mosi, busy, result_valid, result_digit, result_err
  );

  modport slave (
    input  start, in_valid, in_data, miso,
    output in_ready, sck, ss, mosi, busy, result_valid, result_digit, result_err
  );
endinterface

// File: rtl/spi_host_streamer.sv
// Host-side SPI master feeding one image frame to the digit recognizer.
//
// Pixel bytes arrive on a valid/ready stream and are shifted out MSB first
// in SPI mode 0. After the last byte, ss is held high for GAP_CYCLES while
// the network computes, then an 8-bit read returns the detected digit.
//
// Ports:
//   clk - system clock, all logic on the rising edge
//   rst - synchronous active-high reset
//   bus - spi_host_streamer_if.slave (stream in, SPI pins, result out)
//
// Parameters:
//   CLK_DIV    - clk cycles per SCK half-period (>= 2)
//   NUM_BYTES  - pixel bytes per frame
//   GAP_CYCLES - clk cycles ss stays high between frame write and result read
module spi_host_streamer #(
  parameter int CLK_DIV    = 4,
  parameter int NUM_BYTES  = 98,
  parameter int GAP_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_host_streamer_if.slave   bus
);

  localparam int DIV_W  = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int BYTE_W = (NUM_BYTES  > 1) ? $clog2(NUM_BYTES)  : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    READ,
    DONE
  } state_e;

  state_e            state_q,        state_d;
  logic [DIV_W-1:0]  div_cnt_q,      div_cnt_d;
  logic [2:0]        bit_cnt_q,      bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q,     byte_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q,      gap_cnt_d;
  logic [7:0]        shift_reg_q,    shift_reg_d;
  logic [7:0]        rx_reg_q,       rx_reg_d;
  logic              sck_q,          sck_d;
  logic              ss_q,           ss_d;
  logic              mosi_q,         mosi_d;
  logic              in_ready_q,     in_ready_d;
  logic              busy_q,         busy_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        result_digit_q, result_digit_d;
  logic              result_err_q,   result_err_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    shift_reg_d    = shift_reg_q;
    rx_reg_d       = rx_reg_q;
    sck_d          = sck_q;
    ss_d           = ss_q;
    mosi_d         = mosi_q;
    in_ready_d     = in_ready_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    result_digit_d = result_digit_q;
    result_err_d   = result_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d        = LOAD;
          busy_d         = 1'b1;
          ss_d           = 1'b0;
          in_ready_d     = 1'b1;
          result_digit_d = 4'd0;
          result_err_d   = 1'b0;
        end
      end

      // Waits indefinitely for a byte; sck stays low and ss stays asserted.
      LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          state_d     = SHIFT;
          in_ready_d  = 1'b0;
          shift_reg_d = bus.in_data;
          mosi_d      = bus.in_data[7];
          div_cnt_d   = '0;
          bit_cnt_d   = 3'd0;
        end
      end

      // Each bit: CLK_DIV cycles with sck low, then CLK_DIV with sck high.
      // mosi only moves on the high-to-low sck transition, so it is stable
      // around every rising edge the target samples on.
      SHIFT, READ: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == READ) begin
              rx_reg_d = {rx_reg_q[6:0], bus.miso};
            end
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q != 3'd7) begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (state_q == SHIFT) begin
                shift_reg_d = shift_reg_q << 1;
                mosi_d      = shift_reg_q[6];
              end
            end else begin
              bit_cnt_d = 3'd0;
              if (state_q == SHIFT) begin
                if (byte_cnt_q != BYTE_LAST) begin
                  byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                  in_ready_d = 1'b1;
                  state_d    = LOAD;
                end else begin
                  byte_cnt_d = '0;
                  gap_cnt_d  = '0;
                  ss_d       = 1'b1;
                  mosi_d     = 1'b0;
                  state_d    = GAP;
                end
              end else begin
                // The last miso sample was taken on the rising edge of this
                // bit, so rx_reg_q already holds the full byte.
                ss_d           = 1'b1;
                result_valid_d = 1'b1;
                result_digit_d = rx_reg_q[3:0];
                result_err_d   = (rx_reg_q[7:4] != 4'd0) || (rx_reg_q[3:0] > 4'd9);
                state_d        = DONE;
              end
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          div_cnt_d = '0;
          bit_cnt_d = 3'd0;
          rx_reg_d  = 8'd0;
          ss_d      = 1'b0;
          state_d   = READ;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      // start is deliberately not looked at here; a new frame needs IDLE.
      DONE: begin
        result_valid_d = 1'b0;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= 3'd0;
      byte_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      shift_reg_q    <= 8'd0;
      rx_reg_q       <= 8'd0;
      sck_q          <= 1'b0;
      ss_q           <= 1'b1;
      mosi_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_digit_q <= 4'd0;
      result_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      shift_reg_q    <= shift_reg_d;
      rx_reg_q       <= rx_reg_d;
      sck_q          <= sck_d;
      ss_q           <= ss_d;
      mosi_q         <= mosi_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_digit_q <= result_digit_d;
      result_err_q   <= result_err_d;
    end
  end

  assign bus.sck          = sck_q;
  assign bus.ss           = ss_q;
  assign bus.mosi         = mosi_q;
  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_digit = result_digit_q;
  assign bus.result_err   = result_err_q;

endmodule

// File: tb/tb_spi_host_streamer.sv
// Self-checking bench for spi_host_streamer with a small frame
// (2 bytes, CLK_DIV=2, GAP_CYCLES=10). A mode-0 SPI target model captures
// mosi bytes and returns a programmed response on miso; expected bytes and
// results are queued when stimulus is driven and compared as they appear.
module tb_spi_host_streamer;
  localparam int CLK_DIV    = 2;
  localparam int NUM_BYTES  = 2;
  localparam int GAP_CYCLES = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_host_streamer_if bus ();

  spi_host_streamer #(
    .CLK_DIV    (CLK_DIV),
    .NUM_BYTES  (NUM_BYTES),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_byte_q[$];
  logic [7:0] got_byte_q[$];
  logic [4:0] exp_res_q[$];
  logic [7:0] slave_resp = 8'h00;

  // Target model state, owned by the monitor process only.
  int         wr_edges   = 0;
  int         rd_edges   = 0;
  int         gap_events = 0;
  int         gap_seen   = 0;
  int         gap_run    = 0;
  int         wr_bits    = 0;
  int         rd_bit     = 0;
  bit         after_gap  = 1'b0;
  bit         prev_sck   = 1'b0;
  logic [7:0] wr_shift   = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      bus.miso  = 1'b0;
      prev_sck  = 1'b0;
      after_gap = 1'b0;
      wr_bits   = 0;
      rd_bit    = 0;
      gap_run   = 0;
    end else begin
      if (!bus.busy)   after_gap = 1'b0;
      else if (bus.ss) after_gap = 1'b1;

      if (bus.busy && bus.ss) begin
        gap_run++;
      end else begin
        if (gap_run != 0 && bus.busy) begin
          gap_seen = gap_run;
          gap_events++;
        end
        gap_run = 0;
      end

      if (bus.ss) begin
        wr_bits  = 0;
        rd_bit   = 0;
        bus.miso = slave_resp[7];
      end else if (!prev_sck && bus.sck) begin
        if (after_gap) begin
          rd_edges++;
        end else begin
          wr_edges++;
          wr_shift = {wr_shift[6:0], bus.mosi};
          wr_bits++;
          if (wr_bits == 8) begin
            got_byte_q.push_back(wr_shift);
            wr_bits = 0;
          end
        end
      end else if (prev_sck && !bus.sck) begin
        rd_bit++;
        if (rd_bit < 8) bus.miso = slave_resp[7 - rd_bit];
      end
      prev_sck = bus.sck;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain_bytes();
    check("mosi_byte_count", got_byte_q.size(), exp_byte_q.size());
    while (got_byte_q.size() > 0 && exp_byte_q.size() > 0) begin
      logic [7:0] g;
      logic [7:0] e;
      g = got_byte_q.pop_front();
      e = exp_byte_q.pop_front();
      check("mosi_byte", g, e);
    end
    got_byte_q.delete();
    exp_byte_q.delete();
  endtask

  // One complete frame: two bytes, optional underrun before byte 2, and
  // optional start pulses during GAP and in the DONE cycle.
  task automatic run_frame(input logic [15:0] bytes, input logic [7:0] resp,
                           input int underrun, input bit poke_start);
    int         wr0;
    int         rd0;
    int         ge0;
    bit         ok;
    logic [4:0] exp_res;
    logic [7:0] b;

    wr0 = wr_edges;
    rd0 = rd_edges;
    ge0 = gap_events;
    slave_resp = resp;
    exp_res = {((resp[7:4] != 4'd0) || (resp[3:0] > 4'd9)), resp[3:0]};
    exp_res_q.push_back(exp_res);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_ss", bus.ss, 0);
    check("start_result_cleared", {bus.result_err, bus.result_digit}, 0);
    check("load_in_ready", bus.in_ready, 1);

    for (int i = 0; i < NUM_BYTES; i++) begin
      b = bytes[15 - 8*i -: 8];
      if (i == 1 && underrun > 0) begin
        bus.in_valid = 1'b0;
        wait_ready(ok);
        check("underrun_reaches_load", ok, 1);
        repeat (underrun) begin
          @(negedge clk);
          check("underrun_pins", {bus.ss, bus.sck, bus.in_ready}, 3'b001);
        end
        check("underrun_edges", wr_edges - wr0, 8);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      exp_byte_q.push_back(b);
      wait_ready(ok);
      check("handshake", ok, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    if (poke_start) begin
      ok = 1'b0;
      for (int k = 0; k < 500; k++) begin
        if (bus.ss) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("reach_gap", ok, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end

    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.result_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("result_valid_seen", ok, 1);
    if (ok && exp_res_q.size() > 0) begin
      exp_res = exp_res_q.pop_front();
      check("result_err_digit", {bus.result_err, bus.result_digit}, exp_res);
      check("done_busy", bus.busy, 1);
    end
    if (poke_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("valid_one_cycle", bus.result_valid, 0);
    check("busy_drop", bus.busy, 0);
    check("write_edges", wr_edges - wr0, 16);
    check("read_edges", rd_edges - rd0, 8);
    check("gap_events", gap_events - ge0, 1);
    check("gap_length", gap_seen, GAP_CYCLES);
    drain_bytes();

    repeat (poke_start ? 20 : 3) begin
      @(negedge clk);
      check("idle_after_done", {bus.busy, bus.ss, bus.sck, bus.in_ready}, 4'b0100);
    end
    check("result_held", {bus.result_err, bus.result_digit}, exp_res);
  endtask

  initial begin
    int wr0;
    bit ok;

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.ss, bus.sck, bus.mosi, bus.in_ready, bus.busy,
           bus.result_valid, bus.result_err, bus.result_digit},
          11'b100_0000_0000);
    rst = 1'b0;

    repeat (50) begin
      @(negedge clk);
      check("idle_pins", {bus.ss, bus.sck, bus.mosi, bus.busy, bus.in_ready}, 5'b10000);
    end

    run_frame(16'hA53C, 8'h07, 0, 1'b0);
    run_frame(16'h5AF0, 8'h1B, 20, 1'b0);
    run_frame(16'h817E, 8'h09, 0, 1'b1);

    // Abort a frame partway through the first byte.
    wr0 = wr_edges;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_data  = 8'hE7;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (wr_edges - wr0 >= 4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_bit4", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_pins", {bus.ss, bus.sck, bus.busy, bus.in_ready, bus.mosi}, 5'b10000);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_reset_no_byte", got_byte_q.size(), 0);
    got_byte_q.delete();
    repeat (3) @(negedge clk);

    run_frame(16'hC396, 8'hF3, 0, 1'b0);
    run_frame(16'h0FFF, 8'h0A, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
